clkdiv_multi: RTL and testbench

- Parametrised successor of the single-output frequency divider.
- Provides NCH independent clock-enable/waveform generators from one system clock.
- Each channel has a programmable period, a programmable high time (duty cycle), an enable, and a one-cycle tick.
- Configuration writes go through a valid/ready port into per-channel shadow registers and are applied only at period boundaries, so outputs never glitch on reprogramming.

---
 rtl/clkdiv_pkg.sv | 39 +++
 rtl/clkdiv_chan.sv | 110 +++++++++++
 rtl/clkdiv_multi.sv | 70 +++++++
 tb/tb_clkdiv_multi.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Optional build macro: CLKDIV_SYNC_EN (adds a sync_i phase-align input to clkdiv_multi).
package clkdiv_pkg;

    // Default counter width and the matching count type.
    localparam int CNT_W = 26;
    typedef logic [CNT_W-1:0] cnt_t;

    // Channel index type, wide enough for the 16-channel maximum.
    localparam int MAX_CH = 16;
    typedef logic [3:0] chan_idx_t;

    // Reset defaults: 1 Hz square wave from a 60 MHz system clock.
    localparam int unsigned CLKDIV_DEF_PERIOD = 32'd59999999;
    localparam int unsigned CLKDIV_DEF_HIGH   = 32'd30000000;

    // Frequency-select constants: period-minus-one values for a 60 MHz clock.
    localparam cnt_t FSEL_1HZ    = 26'd59999999;
    localparam cnt_t FSEL_10HZ   = 26'd5999999;
    localparam cnt_t FSEL_100HZ  = 26'd599999;
    localparam cnt_t FSEL_1KHZ   = 26'd59999;
    localparam cnt_t FSEL_10KHZ  = 26'd5999;
    localparam cnt_t FSEL_100KHZ = 26'd599;
    localparam cnt_t FSEL_1MHZ   = 26'd59;
    localparam cnt_t FSEL_10MHZ  = 26'd5;
    localparam cnt_t FSEL_30MHZ  = 26'd1;

    // Per-channel run state: IDLE means the next enabled cycle starts a fresh period.
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_t;

    // Width of the channel select field; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active and shadow period/high registers,
// pending flag and registered waveform/tick outputs.
// Outputs are computed one cycle ahead so that, in every cycle,
// div_out == (cnt < H) and div_tick == (cnt == 0) for the cnt held that cycle.
// Handshake: wr is a single-cycle transfer strobe; the parent only raises it
// while busy is low, so a write and an apply never coincide.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int          WIDTH      = CNT_W,
    parameter int unsigned DEF_PERIOD = CLKDIV_DEF_PERIOD,
    parameter int unsigned DEF_HIGH   = CLKDIV_DEF_HIGH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_period,
    input  logic [WIDTH-1:0] wr_high,
    output logic             busy,
    output logic             div_out,
    output logic             div_tick
);

    chan_state_t      state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] act_p, act_p_n;
    logic [WIDTH-1:0] act_h, act_h_n;
    logic [WIDTH-1:0] shd_p, shd_p_n;
    logic [WIDTH-1:0] shd_h, shd_h_n;
    logic             busy_n, out_n, tick_n;

    logic [WIDTH-1:0] cnt_inc;
    logic             wrap, restart, apply;

    assign cnt_inc = cnt + WIDTH'(1);
    assign wrap    = (cnt == act_p);
    // A fresh period starts after a wrap, a sync pulse, or when leaving idle.
    assign restart = (state == CH_IDLE) || sync || wrap;
    // Pending settings go live at a period boundary or at any time while disabled.
    assign apply   = busy && (!en || restart);

    // Next-state, shadow/active update and output lookahead.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        act_p_n  = act_p;
        act_h_n  = act_h;
        shd_p_n  = shd_p;
        shd_h_n  = shd_h;
        busy_n   = busy;
        out_n    = div_out;
        tick_n   = div_tick;

        if (apply) begin
            act_p_n = shd_p;
            act_h_n = shd_h;
            busy_n  = 1'b0;
        end

        if (wr) begin
            shd_p_n = wr_period;
            shd_h_n = wr_high;
            busy_n  = 1'b1;
        end

        if (!en) begin
            state_n = CH_IDLE;
            cnt_n   = '0;
            out_n   = 1'b0;
            tick_n  = 1'b0;
        end else if (restart) begin
            state_n = CH_RUN;
            cnt_n   = '0;
            tick_n  = 1'b1;
            out_n   = (act_h_n != '0);
        end else begin
            cnt_n   = cnt_inc;
            tick_n  = 1'b0;
            out_n   = (cnt_inc < act_h);
        end
    end

    // State register with synchronous reset to the default configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CH_IDLE;
            cnt      <= '0;
            act_p    <= WIDTH'(DEF_PERIOD);
            act_h    <= WIDTH'(DEF_HIGH);
            shd_p    <= '0;
            shd_h    <= '0;
            busy     <= 1'b0;
            div_out  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            act_p    <= act_p_n;
            act_h    <= act_h_n;
            shd_p    <= shd_p_n;
            shd_h    <= shd_h_n;
            busy     <= busy_n;
            div_out  <= out_n;
            div_tick <= tick_n;
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// NCH independent clock-enable/waveform generators sharing one system clock.
// Handshake: a configuration transfer happens in any cycle where cfg_valid and
// cfg_ready are both high; cfg_ready is combinational from cfg_chan and is low
// only while the addressed channel still holds an unapplied setting.
// Out-of-range channel indices are always ready and their writes are dropped.
// Optional build macro: CLKDIV_SYNC_EN adds sync_i, which restarts every
// enabled channel at cnt=0 on the next cycle and applies all pending settings.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int          NCH        = 4,
    parameter int          WIDTH      = CNT_W,
    parameter int unsigned DEF_PERIOD = CLKDIV_DEF_PERIOD,
    parameter int unsigned DEF_HIGH   = CLKDIV_DEF_HIGH
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef CLKDIV_SYNC_EN
    input  logic                     sync_i,
`endif
    input  logic [NCH-1:0]           chan_en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [chan_w(NCH)-1:0]   cfg_chan,
    input  logic [WIDTH-1:0]         cfg_period,
    input  logic [WIDTH-1:0]         cfg_high,
    output logic [NCH-1:0]           div_out,
    output logic [NCH-1:0]           div_tick,
    output logic [NCH-1:0]           busy
);

    localparam int CW = chan_w(NCH);

    logic chan_ok;
    logic xfer;
    logic sync_all;

`ifdef CLKDIV_SYNC_EN
    assign sync_all = sync_i;
`else
    assign sync_all = 1'b0;
`endif

    assign chan_ok   = (32'(cfg_chan) < NCH);
    assign cfg_ready = chan_ok ? !busy[cfg_chan] : 1'b1;
    assign xfer      = cfg_valid && cfg_ready && chan_ok;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic wr;
        assign wr = xfer && (cfg_chan == CW'(g));

        clkdiv_chan #(
            .WIDTH      (WIDTH),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (chan_en[g]),
            .sync       (sync_all),
            .wr         (wr),
            .wr_period  (cfg_period),
            .wr_high    (cfg_high),
            .busy       (busy[g]),
            .div_out    (div_out[g]),
            .div_tick   (div_tick[g])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi (NCH=4, WIDTH=8, DEF_PERIOD=9, DEF_HIGH=5).
// The driver schedules inputs on absolute cycle numbers and queues the expected
// per-cycle outputs; a negedge monitor compares every entry due this cycle.
module tb_clkdiv_multi;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] chan_en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_chan;
    logic [W-1:0]   cfg_period;
    logic [W-1:0]   cfg_high;
    logic [NCH-1:0] div_out;
    logic [NCH-1:0] div_tick;
    logic [NCH-1:0] busy;
`ifdef CLKDIV_SYNC_EN
    logic           sync_i;
`endif

    clkdiv_multi #(
        .NCH        (NCH),
        .WIDTH      (W),
        .DEF_PERIOD (9),
        .DEF_HIGH   (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CLKDIV_SYNC_EN
        .sync_i     (sync_i),
`endif
        .chan_en    (chan_en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .div_out    (div_out),
        .div_tick   (div_tick),
        .busy       (busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef enum int {K_OUT, K_TICK, K_BUSY, K_RDY} kind_t;
    typedef struct {
        int    cyc;
        kind_t kind;
        int    ch;
        logic  val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic string kname(input kind_t k);
        case (k)
            K_OUT:   return "div_out";
            K_TICK:  return "div_tick";
            K_BUSY:  return "busy";
            default: return "cfg_ready";
        endcase
    endfunction

    function automatic logic actual(input kind_t k, input int ch);
        case (k)
            K_OUT:   return div_out[ch];
            K_TICK:  return div_tick[ch];
            K_BUSY:  return busy[ch];
            default: return cfg_ready;
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic a;
        n_vec++;
        if (e.cyc < cyc) begin
            n_err++;
            $display("FAIL stale_%s ch%0d cycle %0d: not checked in time (now %0d)",
                     kname(e.kind), e.ch, e.cyc, cyc);
        end else begin
            a = actual(e.kind, e.ch);
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s ch%0d cycle %0d: got %b, expected %b",
                         kname(e.kind), e.ch, e.cyc, a, e.val);
            end
        end
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                check(exp_q[i]);
                exp_q.delete(i);
            end
        end
    end

    // ---------------- expectation helpers ----------------
    task automatic push_one(input int c, input kind_t k, input int ch, input logic v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Running channel whose cnt was 0 at cycle 'start': cnt = (c-start) mod (p+1).
    task automatic push_run(input int ch, input int c_from, input int c_to,
                            input int start, input int p, input int h);
        for (int c = c_from; c <= c_to; c++) begin
            int k;
            k = (c - start) % (p + 1);
            push_one(c, K_OUT,  ch, (k < h));
            push_one(c, K_TICK, ch, (k == 0));
        end
    endtask

    task automatic push_zero(input int ch, input int c_from, input int c_to);
        for (int c = c_from; c <= c_to; c++) begin
            push_one(c, K_OUT,  ch, 1'b0);
            push_one(c, K_TICK, ch, 1'b0);
        end
    endtask

    task automatic push_busy(input int ch, input int c_from, input int c_to, input logic v);
        for (int c = c_from; c <= c_to; c++) push_one(c, K_BUSY, ch, v);
    endtask

    // ---------------- driver ----------------
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int ch, input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_chan   = 2'(ch);
        cfg_period = 8'(p);
        cfg_high   = 8'(h);
    endtask

    int c0, s, r, q;

    initial begin
        rst        = 1'b1;
        chan_en    = '0;
        cfg_valid  = 1'b0;
        cfg_chan   = '0;
        cfg_period = '0;
        cfg_high   = '0;
`ifdef CLKDIV_SYNC_EN
        sync_i     = 1'b0;
`endif

        // Reset state, then release with all channels enabled.
        c0 = 3;
        goto(c0);
        for (int ch = 0; ch < NCH; ch++) begin
            push_zero(ch, c0, c0);
            push_busy(ch, c0, c0, 1'b0);
        end
        rst     = 1'b0;
        chan_en = 4'hF;
        s = c0 + 1;
        push_run(0, s, s + 49, s, 9, 5);
        push_run(1, s, s + 19, s, 9, 5);
        push_run(2, s, s + 19, s, 9, 5);
        push_run(3, s, s + 80, s, 9, 5);

        // ch1 P=3 H=1 written mid-period (cnt=2); takes effect after cnt=9.
        goto(s + 12);
        push_busy(1, s + 12, s + 12, 1'b0);
        push_one(s + 12, K_RDY, 1, 1'b1);
        cfg_write(1, 3, 1);
        push_busy(1, s + 13, s + 19, 1'b1);
        push_busy(1, s + 20, s + 20, 1'b0);
        push_one(s + 20, K_RDY, 1, 1'b1);
        push_run(1, s + 20, s + 111, s + 20, 3, 1);
        goto(s + 13);
        cfg_valid = 1'b0;

        // Second write to busy ch1 is refused; ch2 write accepted meanwhile.
        goto(s + 14);
        cfg_write(1, 0, 0);
        push_one(s + 14, K_RDY, 1, 1'b0);
        goto(s + 15);
        cfg_write(2, 4, 2);
        push_one(s + 15, K_RDY, 2, 1'b1);
        push_busy(2, s + 16, s + 19, 1'b1);
        push_busy(2, s + 20, s + 20, 1'b0);
        push_run(2, s + 20, s + 111, s + 20, 4, 2);
        goto(s + 16);
        cfg_valid = 1'b0;

        // ch0 boundaries: H=0, H>P, P=0.
        goto(s + 41);
        cfg_write(0, 9, 0);
        push_busy(0, s + 42, s + 49, 1'b1);
        push_busy(0, s + 50, s + 50, 1'b0);
        push_run(0, s + 50, s + 59, s + 50, 9, 0);
        goto(s + 42);
        cfg_valid = 1'b0;
        goto(s + 51);
        cfg_write(0, 9, 12);
        push_run(0, s + 60, s + 69, s + 60, 9, 12);
        goto(s + 52);
        cfg_valid = 1'b0;
        goto(s + 61);
        cfg_write(0, 0, 1);
        push_run(0, s + 70, s + 111, s + 70, 0, 1);
        goto(s + 62);
        cfg_valid = 1'b0;

        // ch3 disabled for 7 cycles; a write while disabled applies at once.
        goto(s + 80);
        chan_en[3] = 1'b0;
        push_zero(3, s + 81, s + 87);
        goto(s + 82);
        cfg_write(3, 4, 3);
        push_one(s + 82, K_RDY, 3, 1'b1);
        push_busy(3, s + 83, s + 83, 1'b1);
        push_busy(3, s + 84, s + 84, 1'b0);
        goto(s + 83);
        cfg_valid = 1'b0;
        goto(s + 87);
        chan_en[3] = 1'b1;
        push_run(3, s + 88, s + 111, s + 88, 4, 3);

        // Reset while a ch2 write is pending: shadow lost, defaults restored.
        r = s + 112;
        goto(r);
        cfg_write(2, 2, 1);
        push_one(r, K_RDY, 2, 1'b1);
        push_busy(2, r + 1, r + 2, 1'b1);
        goto(r + 1);
        cfg_valid = 1'b0;
        goto(r + 2);
        rst = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            push_zero(ch, r + 3, r + 3);
            push_busy(ch, r + 3, r + 3, 1'b0);
        end
        goto(r + 3);
        rst = 1'b0;
        q = r + 26;

`ifdef CLKDIV_SYNC_EN
        push_run(0, r + 4, q,     r + 4, 9, 5);
        push_run(1, r + 4, q + 4, r + 4, 9, 5);
        push_run(2, r + 4, q + 4, r + 4, 9, 5);
        push_run(3, r + 4, q + 4, r + 4, 9, 5);
        // Offset ch0 by a one-cycle disable, queue ch1 P=4 H=2, then sync.
        goto(q);
        chan_en[0] = 1'b0;
        cfg_write(1, 4, 2);
        push_one(q, K_RDY, 1, 1'b1);
        push_zero(0, q + 1, q + 1);
        push_busy(1, q + 1, q + 4, 1'b1);
        goto(q + 1);
        chan_en[0] = 1'b1;
        cfg_valid  = 1'b0;
        push_run(0, q + 2, q + 4, q + 2, 9, 5);
        goto(q + 4);
        sync_i = 1'b1;
        push_busy(1, q + 5, q + 5, 1'b0);
        push_run(0, q + 5, q + 25, q + 5, 9, 5);
        push_run(1, q + 5, q + 25, q + 5, 4, 2);
        push_run(2, q + 5, q + 25, q + 5, 9, 5);
        push_run(3, q + 5, q + 25, q + 5, 9, 5);
        goto(q + 5);
        sync_i = 1'b0;
`else
        for (int ch = 0; ch < NCH; ch++) push_run(ch, r + 4, q + 20, r + 4, 9, 5);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
